me_pixel_feeder: RTL
====================

Name: me_pixel_feeder

Overview:
- Streams one macroblock job into the motion-estimation core, playing the role of the pixel source for the ME pixel ports.
- Reads the current macroblock and its search window from two column-organised synchronous-read buffers.
- Issues the one-cycle start pulse, then drives the current-pixel columns, then the search-window strips in the exact beat order the ME core consumes.
- Sits between the frame buffer fetch logic and the ME core.

Parameters:
- MACRO_DIM, 16: macroblock edge in pixels.
- SEARCH_DIM, 48: search window edge in pixels.
- ADDR_W, 12: address width of both buffers.
- Derived: PORT_WIDTH = MACRO_DIM+1.
- Derived: NUM_STRIPS = ceil(SEARCH_DIM/PORT_WIDTH), which is 3 at default values.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  job request, sampled in IDLE only.
- abort  in  1  cancel the current job.
- cur_base  in  ADDR_W  base address of the current-MB buffer, latched on accept.
- srch_base  in  ADDR_W  base address of the search buffer, latched on accept.
- cur_rd_en  out  1  current buffer read strobe.
- cur_rd_addr  out  ADDR_W  current buffer read address.
- cur_rd_data  in  MACRO_DIM*8  one column of the current MB; lane r = row r; valid 1 cycle after cur_rd_en.
- srch_rd_en  out  1  search buffer read strobe.
- srch_rd_addr  out  ADDR_W  search buffer read address.
- srch_rd_data  in  PORT_WIDTH*8  one strip; lane k = row strip*PORT_WIDTH+k; valid 1 cycle after srch_rd_en.
- start  out  1  one-cycle pulse to the ME core.
- pixel_cpr_out  out  [7:0] x MACRO_DIM  current column to the ME.
- pixel_spr_out  out  [7:0] x PORT_WIDTH  search strip to the ME.
- cpr_valid  out  1  pixel_cpr_out carries a column.
- spr_valid  out  1  pixel_spr_out carries a strip.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs are 0; pixel outputs are all-zero lanes.
- FSM states: IDLE, START, CUR, SRCH, DONE.
- IDLE:
  - req=1 at edge T: latch both bases; busy=1 from T+1; go to START.
  - req while busy is ignored, with no queueing.
- START (cycle T+1):
  - start=1.
  - cur_rd_en=1 with cur_rd_addr=cur_base+0.
- CUR:
  - Column c (0..MACRO_DIM-1) is read at T+1+c and presented at T+2+c with cpr_valid=1.
  - Read addresses are pipelined one cycle ahead, so there are no bubbles.
- SRCH:
  - Each search column i (0..SEARCH_DIM-1) occupies NUM_STRIPS+1 cycles: NUM_STRIPS strip beats with spr_valid=1, then one gap cycle with spr_valid=0 and zero data.
  - The first strip of column 0 is presented at T+2+MACRO_DIM.
  - srch_rd_addr = srch_base + i*NUM_STRIPS + s. Use an incrementing counter, not a multiplier.
  - There is no read during gap cycles.
- Lane masking: in strip s, lane k is forced to 0 when s*PORT_WIDTH+k >= SEARCH_DIM. At default values, lanes 14..16 of strip 2 are masked.
- DONE:
  - done=1 for one cycle at T+2+MACRO_DIM+SEARCH_DIM*(NUM_STRIPS+1), which is T+210 at default values.
  - busy=0 in that same cycle; return to IDLE.
- Whenever the corresponding valid is 0, pixel_cpr_out and pixel_spr_out are driven to zero.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE, all outputs 0, no done.
  - An in-flight read result is discarded.
  - abort in IDLE has no effect.
- Simultaneous abort and req in IDLE: req is accepted and abort is ignored.
- rst asserted mid-job has the same effect as abort, and also clears the latched bases.
- Address arithmetic wraps modulo 2^ADDR_W without error.

Optional Feature:
- Macro: ME_FEEDER_PERF_EN.
- When defined:
  - Adds output job_cnt [15:0]. It increments on each done, wraps at 0xFFFF to 0, and is cleared by rst but not by abort.
  - Adds output abort_cnt [7:0], which saturates at 0xFF.
- When undefined: neither port nor its counters exist.

Decomposition:
- Package me_pkg holds:
  - MACRO_DIM, SEARCH_DIM, PORT_WIDTH and NUM_STRIPS defaults;
  - the pixel_t typedef (8-bit);
  - the feeder state enum.
- One natural sub-module: me_strip_mask, which is combinational and computes the lane mask from the strip index. It is instantiated once.

Test Plan:
- Basic job: cur_base=0x000, srch_base=0x100, buffer models return address-derived pixels; req at T.
  - start at T+1.
  - Columns 0..15 with cpr_valid on T+2..T+17.
  - First strip at T+18 from address 0x100.
  - done at T+210.
- Strip order and gaps: check column 0 beat sequence 0x100, 0x101, 0x102, then a gap, then 0x103 on column 1. Check spr_valid is low exactly every 4th search cycle.
- Masking: the buffer returns 0xFF in all lanes. Strip 2 lanes 14..16 must be 0x00; strip 0 and strip 1 lanes stay 0xFF.
- Abort at T+50: next cycle busy=0, all outputs 0, no done. A new req at T+55 produces a full, correct job.
- req pulses at T+5 and T+100 during a job are ignored. Exactly one done, at T+210.
- Reset at T+20 clears everything. With ME_FEEDER_PERF_EN defined, two back-to-back jobs give job_cnt=2, and rst returns it to 0.

Source files
------------

// File: rtl/me_pixel_feeder_pkg.sv
// me_pkg: geometry defaults, pixel type and feeder state encoding shared by the ME pixel feeder
package me_pkg;
  localparam int MACRO_DIM = 16;
  localparam int SEARCH_DIM = 48;
  localparam int ADDR_W = 12;
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NUM_STRIPS = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int STRIP_W = $clog2(NUM_STRIPS + 1);
  localparam int COL_W = $clog2(MACRO_DIM);
  localparam int SCOL_W = $clog2(SEARCH_DIM);
  typedef logic [7:0] pixel_t;
  typedef enum logic [2:0] {IDLE, START, CUR, SRCH, DONE} state_t;
endpackage

// File: rtl/me_pixel_feeder_if.sv
// me_pixel_feeder_if: job control, buffer read ports and ME pixel ports; ME_FEEDER_PERF_EN adds job_cnt/abort_cnt
interface me_pixel_feeder_if;
  import me_pkg::*;
  logic req, abort;
  logic [ADDR_W-1:0] cur_base, srch_base, cur_rd_addr, srch_rd_addr;
  logic cur_rd_en, srch_rd_en, start, cpr_valid, spr_valid, busy, done;
  logic [MACRO_DIM*8-1:0] cur_rd_data;
  logic [PORT_WIDTH*8-1:0] srch_rd_data;
  pixel_t [MACRO_DIM-1:0] pixel_cpr_out;
  pixel_t [PORT_WIDTH-1:0] pixel_spr_out;
`ifdef ME_FEEDER_PERF_EN
  logic [15:0] job_cnt;
  logic [7:0] abort_cnt;
  modport master (
    input req, abort, cur_base, srch_base, cur_rd_data, srch_rd_data,
    output cur_rd_en, cur_rd_addr, srch_rd_en, srch_rd_addr, start, pixel_cpr_out, pixel_spr_out,
    output cpr_valid, spr_valid, busy, done, job_cnt, abort_cnt
  );
  modport slave (
    output req, abort, cur_base, srch_base, cur_rd_data, srch_rd_data,
    input cur_rd_en, cur_rd_addr, srch_rd_en, srch_rd_addr, start, pixel_cpr_out, pixel_spr_out,
    input cpr_valid, spr_valid, busy, done, job_cnt, abort_cnt
  );
`else
  modport master (
    input req, abort, cur_base, srch_base, cur_rd_data, srch_rd_data,
    output cur_rd_en, cur_rd_addr, srch_rd_en, srch_rd_addr, start, pixel_cpr_out, pixel_spr_out,
    output cpr_valid, spr_valid, busy, done
  );
  modport slave (
    output req, abort, cur_base, srch_base, cur_rd_data, srch_rd_data,
    input cur_rd_en, cur_rd_addr, srch_rd_en, srch_rd_addr, start, pixel_cpr_out, pixel_spr_out,
    input cpr_valid, spr_valid, busy, done
  );
`endif
endinterface

// File: rtl/me_pixel_feeder_strip_mask.sv
// me_strip_mask: per-lane enable of a search strip; lanes below the window's bottom edge are off
module me_strip_mask
  import me_pkg::*;
(
  input logic [STRIP_W-1:0] strip,
  output logic [PORT_WIDTH-1:0] mask
);
  // lane k of strip s carries window row s*PORT_WIDTH+k
  always_comb
    for (int k = 0; k < PORT_WIDTH; k++) mask[k] = int'(strip) * PORT_WIDTH + k < SEARCH_DIM;
endmodule

// File: rtl/me_pixel_feeder.sv
// me_pixel_feeder: streams one MB job (start, current columns, masked search strips) into the ME core; ME_FEEDER_PERF_EN adds counters
module me_pixel_feeder
  import me_pkg::*;
(
  input logic clk,
  input logic rst,
  me_pixel_feeder_if.master bus
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MACRO_DIM - 1);
  localparam logic [STRIP_W-1:0] GAP = STRIP_W'(NUM_STRIPS);
  localparam logic [SCOL_W-1:0] SCOL_LAST = SCOL_W'(SEARCH_DIM - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] cur_ptr, srch_ptr;
  logic [COL_W-1:0] col;
  logic [STRIP_W-1:0] strip, strip_q;
  logic [SCOL_W-1:0] scol;
  logic rd_cur, rd_srch, cpr_v, spr_v, done_q;
  logic [PORT_WIDTH-1:0] lane_en;
  me_strip_mask u_mask (.strip(strip_q), .mask(lane_en));
  // next state and read strobes; strip index NUM_STRIPS is the per-column gap slot
  always_comb begin
    rd_cur = state == START || state == CUR;
    rd_srch = state == SRCH && strip != GAP;
    state_nx = state;
    if (state != IDLE && bus.abort) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = bus.req ? START : IDLE;
        START: state_nx = CUR;
        CUR: state_nx = col == COL_LAST ? SRCH : CUR;
        SRCH: state_nx = strip == GAP && scol == SCOL_LAST ? DONE : SRCH;
        default: state_nx = IDLE;
      endcase
  end
  // outputs: read data is forwarded in the cycle after its strobe, zeroed whenever not valid
  always_comb begin
    bus.start = state == START;
    bus.busy = state != IDLE;
    bus.done = done_q;
    bus.cur_rd_en = rd_cur;
    bus.cur_rd_addr = rd_cur ? cur_ptr : '0;
    bus.srch_rd_en = rd_srch;
    bus.srch_rd_addr = rd_srch ? srch_ptr : '0;
    bus.cpr_valid = cpr_v;
    bus.spr_valid = spr_v;
    bus.pixel_cpr_out = cpr_v ? bus.cur_rd_data : '0;
    for (int k = 0; k < PORT_WIDTH; k++)
      bus.pixel_spr_out[k] = spr_v && lane_en[k] ? bus.srch_rd_data[8*k+:8] : '0;
  end
  // state, address pointers and beat counters; abort drops any read still in flight
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur_ptr <= '0;
      srch_ptr <= '0;
      col <= '0;
      strip <= '0;
      strip_q <= '0;
      scol <= '0;
      cpr_v <= 1'b0;
      spr_v <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_nx;
      cpr_v <= rd_cur && !bus.abort;
      spr_v <= rd_srch && !bus.abort;
      done_q <= state == DONE && !bus.abort;
      strip_q <= strip;
      if (state == IDLE && bus.req) begin
        cur_ptr <= bus.cur_base;
        srch_ptr <= bus.srch_base;
        col <= '0;
        strip <= '0;
        scol <= '0;
      end
      if (rd_cur) begin
        cur_ptr <= cur_ptr + 1'b1;
        col <= col + 1'b1;
      end
      if (rd_srch) srch_ptr <= srch_ptr + 1'b1;
      if (state == SRCH) begin
        strip <= strip == GAP ? '0 : strip + 1'b1;
        if (strip == GAP) scol <= scol + 1'b1;
      end
    end
`ifdef ME_FEEDER_PERF_EN
  // job_cnt wraps and survives abort; abort_cnt saturates
  always_ff @(posedge clk)
    if (rst) begin
      bus.job_cnt <= '0;
      bus.abort_cnt <= '0;
    end else begin
      if (done_q) bus.job_cnt <= bus.job_cnt + 1'b1;
      if (state != IDLE && bus.abort && bus.abort_cnt != 8'hFF) bus.abort_cnt <= bus.abort_cnt + 1'b1;
    end
`endif
endmodule
